// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing constants (also used by the sync
// generator), monitor state encoding and counter widths.
package vga_pkg;

  localparam int H_TOTAL_640  = 800;
  localparam int H_ACTIVE_640 = 640;
  localparam int V_TOTAL_480  = 525;
  localparam int V_ACTIVE_480 = 480;

  localparam int COORD_W = 10;
  localparam int MEAS_W  = 11;
  localparam int ERR_W   = 8;

  typedef logic [1:0] mon_state_t;
  localparam mon_state_t ST_SEARCH  = 2'd0;
  localparam mon_state_t ST_ACQUIRE = 2'd1;
  localparam mon_state_t ST_CHECK   = 2'd2;
  localparam mon_state_t ST_LOCKED  = 2'd3;

endpackage

// File: rtl/vga_period_meter.sv
// Saturating event counter that clears on a capture strobe. o_next is the count
// including the current event, so the owner can compare or capture it directly.
module vga_period_meter
  import vga_pkg::*;
#(
  parameter int W = MEAS_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_tick,
  input  logic         i_inc,
  input  logic         i_capture,
  output logic [W-1:0] o_next
);

  logic [W-1:0] r_cnt;

  assign o_next = (i_inc && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= i_capture ? '0 : o_next;
    end
  end

endmodule

// File: rtl/vga_sync_monitor.sv
// VGA timing receiver: measures line/frame geometry, locks onto the expected
// raster and recovers pixel coordinates. Define VGA_MON_STATS_EN for live stats.
//   state    | meaning
//   SEARCH   | no frame reference, waiting for a vsync rise
//   ACQUIRE  | measuring a frame from a vsync rise
//   CHECK    | good frames seen, counting toward LOCK_FRAMES
//   LOCKED   | stream matches; pixels are reported
module vga_sync_monitor
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_640,
  parameter int H_ACTIVE    = H_ACTIVE_640,
  parameter int V_TOTAL     = V_TOTAL_480,
  parameter int V_ACTIVE    = V_ACTIVE_480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pix_en,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_video_on,
  output logic               o_locked,
  output logic               o_pix_valid,
  output logic [COORD_W-1:0] o_pixel_x,
  output logic [COORD_W-1:0] o_pixel_y,
  output logic               o_frame_start,
  output logic [MEAS_W-1:0]  o_h_total_meas,
  output logic [MEAS_W-1:0]  o_v_total_meas,
  output logic [ERR_W-1:0]   o_err_count
);

  localparam logic [MEAS_W-1:0] H_TOT  = MEAS_W'(H_TOTAL);
  localparam logic [MEAS_W-1:0] H_ACT  = MEAS_W'(H_ACTIVE);
  localparam logic [MEAS_W-1:0] V_TOT  = MEAS_W'(V_TOTAL);
  localparam logic [MEAS_W-1:0] V_ACT  = MEAS_W'(V_ACTIVE);
  localparam logic [MEAS_W-1:0] H_WD   = MEAS_W'(2 * H_TOTAL);
  localparam logic [3:0]        LOCK_N = 4'(LOCK_FRAMES);

  logic r_hs, r_vs, r_de;
  logic w_hs_rise, w_vs_rise, w_de_rise;
  logic [MEAS_W-1:0] w_h_next, w_v_next;
  logic [MEAS_W-1:0] r_act_ticks, r_act_lines;
  logic r_bad_line, w_line_bad, w_frame_good, w_watchdog;
  mon_state_t r_state, w_state_next;
  logic [3:0] r_good_frames, w_good_next;
  logic [COORD_W-1:0] r_x, r_y, w_x, w_y;
  logic r_first;

  assign w_hs_rise = i_pix_en & i_hsync & ~r_hs;
  assign w_vs_rise = i_pix_en & i_vsync & ~r_vs;
  assign w_de_rise = i_pix_en & i_video_on & ~r_de;

  vga_period_meter #(.W(MEAS_W)) u_h_meter (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_pix_en),
    .i_inc(1'b1), .i_capture(w_hs_rise), .o_next(w_h_next)
  );

  // A line closing on the vsync-rise tick still belongs to the ending frame.
  vga_period_meter #(.W(MEAS_W)) u_v_meter (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_pix_en),
    .i_inc(w_hs_rise), .i_capture(w_vs_rise), .o_next(w_v_next)
  );

  assign w_line_bad   = w_hs_rise & ~((w_h_next == H_TOT) &&
                        ((r_act_ticks == '0) || (r_act_ticks == H_ACT)));
  assign w_frame_good = (w_v_next == V_TOT) && (r_act_lines == V_ACT) &&
                        !r_bad_line && !w_line_bad;
  assign w_watchdog   = i_pix_en & ~w_hs_rise & (w_h_next == H_WD);

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_frames;
    if (w_watchdog) begin
      w_state_next = ST_SEARCH;
    end else begin
      case (r_state)
        ST_SEARCH:  if (w_vs_rise) w_state_next = ST_ACQUIRE;
        ST_ACQUIRE: if (w_vs_rise && w_frame_good) begin
                      w_good_next  = 4'd1;
                      w_state_next = (LOCK_N <= 4'd1) ? ST_LOCKED : ST_CHECK;
                    end
        ST_CHECK:   if (w_vs_rise) begin
                      if (w_frame_good) begin
                        w_good_next = r_good_frames + 4'd1;
                        if ((r_good_frames + 4'd1) >= LOCK_N) w_state_next = ST_LOCKED;
                      end else begin
                        w_state_next = ST_ACQUIRE;
                      end
                    end
        ST_LOCKED:  if (w_line_bad || (w_vs_rise && !w_frame_good)) w_state_next = ST_SEARCH;
        default:    w_state_next = ST_SEARCH;
      endcase
    end
  end

  assign w_x = w_de_rise ? '0 : r_x + 1'b1;
  assign w_y = w_de_rise ? (r_first ? '0 : r_y + 1'b1) : r_y;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hs <= 1'b0; r_vs <= 1'b0; r_de <= 1'b0;
      r_state <= ST_SEARCH; r_good_frames <= '0;
      r_act_ticks <= '0; r_act_lines <= '0; r_bad_line <= 1'b0;
      r_x <= '0; r_y <= '0; r_first <= 1'b0;
      o_locked <= 1'b0; o_pix_valid <= 1'b0; o_frame_start <= 1'b0;
      o_pixel_x <= '0; o_pixel_y <= '0;
    end else begin
      o_frame_start <= w_vs_rise;
      o_pix_valid   <= i_pix_en & i_video_on & o_locked;
      if (i_pix_en) begin
        r_hs <= i_hsync; r_vs <= i_vsync; r_de <= i_video_on;
        r_state       <= w_state_next;
        r_good_frames <= w_good_next;
        o_locked      <= (w_state_next == ST_LOCKED);
        if (w_hs_rise) r_act_ticks <= MEAS_W'(i_video_on);
        else if (i_video_on && (r_act_ticks != '1)) r_act_ticks <= r_act_ticks + 1'b1;
        if (w_vs_rise) r_act_lines <= MEAS_W'(w_de_rise);
        else if (w_de_rise && (r_act_lines != '1)) r_act_lines <= r_act_lines + 1'b1;
        if (w_vs_rise) r_bad_line <= 1'b0;
        else if (w_line_bad) r_bad_line <= 1'b1;
        if (i_video_on) begin
          r_x <= w_x;
          r_y <= w_y;
          if (o_locked) begin
            o_pixel_x <= w_x;
            o_pixel_y <= w_y;
          end
        end
        if (w_vs_rise) r_first <= 1'b1;
        else if (w_de_rise) r_first <= 1'b0;
      end
    end
  end

`ifdef VGA_MON_STATS_EN
  logic [MEAS_W-1:0] r_h_meas, r_v_meas;
  logic [ERR_W-1:0]  r_err;
  logic              w_err_evt;

  assign w_err_evt = w_watchdog ? ((r_state == ST_LOCKED) || (r_state == ST_CHECK))
                                : ((r_state == ST_LOCKED) &&
                                   (w_line_bad || (w_vs_rise && !w_frame_good)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_meas <= '0; r_v_meas <= '0; r_err <= '0;
    end else begin
      if (w_hs_rise) r_h_meas <= w_h_next;
      if (w_vs_rise) r_v_meas <= w_v_next;
      if (w_err_evt && (r_err != '1)) r_err <= r_err + 1'b1;
    end
  end

  assign o_h_total_meas = r_h_meas;
  assign o_v_total_meas = r_v_meas;
  assign o_err_count    = r_err;
`else
  assign o_h_total_meas = '0;
  assign o_v_total_meas = '0;
  assign o_err_count    = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down raster (40x12 ticks, 32x8 active)
// so that lock, error and relock sequences all fit in a short run.
module tb_vga_sync_monitor;

  localparam int HT = 40, HA = 32, VT = 12, VA = 8;
  localparam int HS_B = 34, HS_E = 37, VS_B = 9, VS_E = 10;
  localparam int LOCK_N = 2;
`ifdef VGA_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, pix_en, hsync, vsync, video_on;
  logic locked, pix_valid, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [10:0] h_meas, v_meas;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .LOCK_FRAMES(LOCK_N)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en), .i_hsync(hsync),
    .i_vsync(vsync), .i_video_on(video_on), .o_locked(locked),
    .o_pix_valid(pix_valid), .o_pixel_x(pixel_x), .o_pixel_y(pixel_y),
    .o_frame_start(frame_start), .o_h_total_meas(h_meas),
    .o_v_total_meas(v_meas), .o_err_count(err_count)
  );

  int n_checks = 0, n_fail = 0;
  logic [19:0] exp_q[$];
  int gh, gv, div, vs_since, exp_err, n_valid;
  bit prev_hs, prev_vs, exp_locked, drop_en, hold_en, arm_brk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_locked"}, locked, 0);
    check_eq({tag, "_pix_valid"}, pix_valid, 0);
    check_eq({tag, "_frame_start"}, frame_start, 0);
    check_eq({tag, "_pixel_x"}, pixel_x, 0);
    check_eq({tag, "_pixel_y"}, pixel_y, 0);
    check_eq({tag, "_h_meas"}, h_meas, 0);
    check_eq({tag, "_v_meas"}, v_meas, 0);
    check_eq({tag, "_err"}, err_count, 0);
  endtask

  task automatic tick(input bit hs, input bit vs, input bit de, input int x, input int y,
                      input bit brk);
    bit vs_rise;
    logic [19:0] e;
    if (div == 2) begin
      pix_en = 1'b0;
      hsync = 1'($urandom); vsync = 1'($urandom); video_on = 1'($urandom);
      @(posedge clk); #1;
      check_eq("idle_frame_start", frame_start, 0);
      check_eq("idle_pix_valid", pix_valid, 0);
      check_eq("idle_locked", locked, exp_locked);
    end
    pix_en = 1'b1; hsync = hs; vsync = vs; video_on = de;
    if (exp_locked && de) exp_q.push_back({10'(x), 10'(y)});
    vs_rise = vs && !prev_vs;
    prev_hs = hs; prev_vs = vs;
    if (brk) begin
      exp_locked = 1'b0; vs_since = 0; exp_err++;
    end else if (vs_rise) begin
      vs_since++;
      if (vs_since >= LOCK_N + 1) exp_locked = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("frame_start", frame_start, vs_rise);
    check_eq("locked", locked, exp_locked);
    if (pix_valid) begin
      n_valid++;
      check_eq("pix_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("pixel_x", pixel_x, e[19:10]);
        check_eq("pixel_y", pixel_y, e[9:0]);
      end
    end
  endtask

  task automatic advance();
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv = (gv + 1) % VT;
    end
  endtask

  // One raster position; drop_en removes the last tick of line 2 (short line),
  // hold_en suppresses hsync on lines 2 and 3 (watchdog).
  task automatic step();
    bit hs, vs, de, brk;
    if (drop_en && gv == 2 && gh == HT - 1) begin
      drop_en = 1'b0; arm_brk = 1'b1;
      advance();
      return;
    end
    hs = (gh >= HS_B && gh < HS_E);
    vs = (gv >= VS_B && gv < VS_E);
    de = (gh < HA && gv < VA);
    brk = 1'b0;
    if (hold_en && (gv == 2 || gv == 3)) hs = 1'b0;
    if (hold_en && gv == 3 && gh == HS_B) brk = 1'b1;
    if (arm_brk && hs && !prev_hs) begin
      brk = 1'b1; arm_brk = 1'b0;
    end
    tick(hs, vs, de, gh, gv, brk);
    advance();
  endtask

  task automatic run_to(input int v, input int h);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(gv == v && gh == h) && n < 4000);
  endtask

  task automatic do_reset(input int nclk);
    reset = 1'b1;
    repeat (nclk) @(posedge clk);
    #1;
    reset = 1'b0;
    prev_hs = 1'b0; prev_vs = 1'b0; exp_locked = 1'b0; vs_since = 0; exp_err = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0; video_on = 1'b0;
    div = 1; gh = 0; gv = 0; vs_since = 0; exp_err = 0; n_valid = 0;
    prev_hs = 0; prev_vs = 0; exp_locked = 0; drop_en = 0; hold_en = 0; arm_brk = 0;
    do_reset(3);
    check_zero("reset");

    // Nominal: lock one clk after the third vsync rise.
    repeat (3) run_to(VS_B, 1);
    check_eq("lock_nominal", locked, 1);
    check_eq("h_meas_nominal", h_meas, STATS ? HT : 0);
    check_eq("v_meas_nominal", v_meas, STATS ? VT : 0);
    check_eq("err_nominal", err_count, 0);
    n_valid = 0;
    run_to(VS_B, 1);
    check_eq("pix_per_frame", n_valid, HA * VA);
    check_eq("sb_drained_frame", exp_q.size(), 0);

    // One short line while locked.
    drop_en = 1'b1;
    run_to(3, HS_B + 1);
    check_eq("unlock_short_line", locked, 0);
    check_eq("err_short_line", err_count, STATS ? exp_err : 0);
    check_eq("h_meas_short_line", h_meas, STATS ? HT - 1 : 0);
    repeat (3) run_to(VS_B, 1);
    check_eq("relock_short_line", locked, 1);

    // hsync held low until the watchdog fires.
    hold_en = 1'b1;
    run_to(3, HS_B + 1);
    hold_en = 1'b0;
    check_eq("unlock_watchdog", locked, 0);
    check_eq("err_watchdog", err_count, STATS ? exp_err : 0);
    repeat (3) run_to(VS_B, 1);
    check_eq("relock_watchdog", locked, 1);

    // One-clk reset mid-frame while locked.
    run_to(4, 10);
    do_reset(1);
    check_zero("reset_mid");
    repeat (3) run_to(VS_B, 1);
    check_eq("relock_after_reset", locked, 1);
    check_eq("err_after_reset", err_count, 0);

    // Half-rate pixel strobe with random inputs on idle cycles.
    run_to(6, 5);
    div = 2;
    do_reset(1);
    check_zero("reset_div2");
    repeat (3) run_to(VS_B, 1);
    check_eq("lock_div2", locked, 1);
    check_eq("h_meas_div2", h_meas, STATS ? HT : 0);
    check_eq("v_meas_div2", v_meas, STATS ? VT : 0);
    n_valid = 0;
    run_to(VS_B, 1);
    check_eq("pix_per_frame_div2", n_valid, HA * VA);
    check_eq("sb_drained_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
